// File: rtl/serial_frame_comparator.sv
// serial_frame_comparator
// Compares two serial bit streams over a frame of FRAME_LEN valid bit pairs.
// Each pair is tested for equality and mismatches are counted. At the end of
// the frame the block reports a match verdict, the error count and a
// one-cycle done pulse.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a frame (sampled only in IDLE)
//   valid    in   a/b carry a bit pair this cycle
//   a, b     in   stream bits
//   busy     out  high while comparing
//   done     out  one-cycle pulse when the frame completes
//   match    out  1 = last frame had zero mismatches (held until next start)
//   err_cnt  out  mismatching bit count of last/current frame
module serial_frame_comparator #(
    parameter  int unsigned FRAME_LEN = 8,
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_next_c;
    logic             last_bit_c;

    // Running error count including the current pair (XNOR == 0 is a miss).
    always_comb begin
        err_next_c = err_cnt + CNT_W'(~(a ~^ b));
        last_bit_c = (bit_cnt == CNT_W'(FRAME_LEN - 1));
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            match   <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COMPARE;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        err_cnt <= '0;
                        match   <= 1'b0;
                    end
                end
                COMPARE: begin
                    // valid=0 simply stalls; there is no timeout.
                    if (valid) begin
                        err_cnt <= err_next_c;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (last_bit_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (err_next_c == '0);
                        end
                    end
                end
                DONE: begin
                    // start is ignored here; it is first seen back in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
